// File: rtl/demux_pkg.sv
// Shared definitions for the 4-port stream demultiplexer and its 2-entry FIFO.
package demux_pkg;
  localparam int NPORT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;
endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO holding {sel, data}; occupancy is exposed as the FIFO state code.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  fifo_state_t   state;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (state != FULL);
  assign pop_ok  = pop && (state != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case (state)
        EMPTY: if (push_ok) state <= ONE;
        ONE: begin
          // Simultaneous push and pop leaves occupancy unchanged.
          if (push_ok && !pop_ok)      state <= FULL;
          else if (pop_ok && !push_ok) state <= EMPTY;
        end
        FULL:    if (pop_ok) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Storage is data-only; validity is carried entirely by state.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = state;

endmodule

// File: rtl/demux_4_stream.sv
// Single-stream to 4-port demultiplexer: 2-entry FIFO, one-hot valid decode, per-port counters.
module demux_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NPORT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_sel,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [4*CNT_W-1:0]     out_cnt
);

  if (NPORT != 4) begin : g_nport_check
    $error("demux_4_stream supports only NPORT = 4");
  end

  logic [WIDTH+SEL_W-1:0] head;
  logic [1:0]             count;
  logic [SEL_W-1:0]       head_sel;
  logic                   not_empty;
  logic                   push;
  logic                   pop;

  // in_ready depends on registered occupancy only, never on out_ready.
  assign in_ready  = (count != FULL);
  assign push      = in_valid && in_ready;
  assign not_empty = (count != EMPTY);
  assign head_sel  = head[WIDTH+SEL_W-1:WIDTH];
  assign pop       = |(out_valid & out_ready);

  demux_fifo2 #(
    .DW(WIDTH + SEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({in_sel, in_data}),
    .dout  (head),
    .count (count)
  );

  always_comb begin
    out_valid = '0;
    if (not_empty) out_valid[head_sel] = 1'b1;
  end

  assign out_data = not_empty ? head[WIDTH-1:0] : '0;

  for (genvar p = 0; p < 4; p++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           cnt <= '0;
      else if (out_valid[p] && out_ready[p]) cnt <= cnt + 8'd1;
    end
    assign out_cnt[p*CNT_W +: CNT_W] = cnt;
  end

endmodule

// File: tb/tb_demux_4_stream.sv
// Directed bench for demux_4_stream: vector table plus reset-while-full and counter-wrap sequences.
module tb_demux_4_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [31:0] out_cnt;

  int total;
  int bad;

  demux_4_stream #(.WIDTH(32), .NPORT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        irdy;
    logic [3:0]  ov;
    logic [31:0] od;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;

    // Outputs are checked on the falling edge, inputs applied 1 after the rising edge.
    //            iv    sel   data           ordy   irdy  ov     od             cnt
    vecs[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'hF, 1'b1, 4'h0, 32'h0,        32'h00000000};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h4, 32'hDEADBEEF, 32'h00000000};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h0, 32'h0,        32'h00010000};
    vecs[3]  = '{1'b1, 2'd0, 32'h11,       4'h0, 1'b1, 4'h0, 32'h0,        32'h00010000};
    vecs[4]  = '{1'b1, 2'd1, 32'h22,       4'h0, 1'b1, 4'h1, 32'h11,       32'h00010000};
    vecs[5]  = '{1'b1, 2'd1, 32'h33,       4'h0, 1'b0, 4'h1, 32'h11,       32'h00010000};
    vecs[6]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b0, 4'h1, 32'h11,       32'h00010000};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h2, 32'h22,       32'h00010001};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h0, 32'h0,        32'h00010101};
    vecs[9]  = '{1'b1, 2'd0, 32'hA0,       4'hF, 1'b1, 4'h0, 32'h0,        32'h00010101};
    vecs[10] = '{1'b1, 2'd1, 32'hA1,       4'hF, 1'b1, 4'h1, 32'hA0,       32'h00010101};
    vecs[11] = '{1'b1, 2'd2, 32'hA2,       4'hF, 1'b1, 4'h2, 32'hA1,       32'h00010102};
    vecs[12] = '{1'b1, 2'd3, 32'hA3,       4'hF, 1'b1, 4'h4, 32'hA2,       32'h00010202};
    vecs[13] = '{1'b1, 2'd0, 32'hA4,       4'hF, 1'b1, 4'h8, 32'hA3,       32'h00020202};
    vecs[14] = '{1'b1, 2'd1, 32'hA5,       4'hF, 1'b1, 4'h1, 32'hA4,       32'h01020202};
    vecs[15] = '{1'b1, 2'd2, 32'hA6,       4'hF, 1'b1, 4'h2, 32'hA5,       32'h01020203};
    vecs[16] = '{1'b1, 2'd3, 32'hA7,       4'hF, 1'b1, 4'h4, 32'hA6,       32'h01020303};
    vecs[17] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h8, 32'hA7,       32'h01030303};
    vecs[18] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h0, 32'h0,        32'h02030303};
    vecs[19] = '{1'b1, 2'd3, 32'hB3,       4'h7, 1'b1, 4'h0, 32'h0,        32'h02030303};
    vecs[20] = '{1'b1, 2'd0, 32'hB0,       4'h7, 1'b1, 4'h8, 32'hB3,       32'h02030303};
    vecs[21] = '{1'b0, 2'd0, 32'h0,        4'h7, 1'b0, 4'h8, 32'hB3,       32'h02030303};
    vecs[22] = '{1'b0, 2'd0, 32'h0,        4'h7, 1'b0, 4'h8, 32'hB3,       32'h02030303};
    vecs[23] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b0, 4'h8, 32'hB3,       32'h02030303};
    vecs[24] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h1, 32'hB0,       32'h03030303};
    vecs[25] = '{1'b0, 2'd0, 32'h0,        4'hF, 1'b1, 4'h0, 32'h0,        32'h03030304};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_cnt",   out_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 26; i++) begin
      in_valid  = vecs[i].iv;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready}, {31'd0, vecs[i].irdy});
      chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].ov});
      chk($sformatf("v%0d_out_data", i),  out_data, vecs[i].od);
      chk($sformatf("v%0d_out_cnt", i),   out_cnt, vecs[i].cnt);
      @(posedge clk);
      #1;
    end

    // Fill to FULL, then assert reset asynchronously
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 32'hC0;
    out_ready = 4'h0;
    @(posedge clk);
    #1;
    in_sel  = 2'd1;
    in_data = 32'hC1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("full_out_valid", {28'd0, out_valid}, 32'h1);
    chk("full_out_cnt",   out_cnt, 32'h03030304);
    #2;
    rst_n = 1'b0;
    out_ready = 4'hF;
    #1;
    chk("arst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("arst_out_data",  out_data, 32'd0);
    chk("arst_out_cnt",   out_cnt, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_cnt", out_cnt, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {28'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // 256 back-to-back transfers to port 1: counter wraps
    out_ready = 4'hF;
    in_sel    = 2'd1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_cnt_255",   out_cnt, 32'h0000FF00);
    chk("wrap_out_valid", {28'd0, out_valid}, 32'h2);
    chk("wrap_out_data",  out_data, 32'd255);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap_cnt_0",      out_cnt, 32'd0);
    chk("wrap_idle_valid", {28'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
